// File: rtl/gnr_ctrl_pkg.sv
// rtl/gnr_ctrl_pkg.sv - shared FSM encoding and defaults for the GRN attractor controller
package gnr_ctrl_pkg;

  localparam int GNR_N_DEF     = 22;
  localparam int GNR_CNT_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_PERIOD = 3'd3,
    ST_DONE   = 3'd4
  } gnr_state_e;

endpackage

// File: rtl/gnr_step_cnt.sv
// rtl/gnr_step_cnt.sv - step counter with clear, enable and a budget-reached flag
module gnr_step_cnt
  import gnr_ctrl_pkg::*;
#(
  parameter int CNT_W = GNR_CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_limit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign at_limit_o = (cnt_q == limit_i);

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// rtl/gnr_attractor_ctrl.sv - Floyd tortoise/hare sequencer finding the meet index and period of a GRN attractor
module gnr_attractor_ctrl
  import gnr_ctrl_pkg::*;
#(
  parameter int N     = GNR_N_DEF,
  parameter int CNT_W = GNR_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     seed,
  input  logic [CNT_W-1:0] max_steps,
  input  logic [N-1:0]     s0_vec,
  input  logic [N-1:0]     s1_vec,
  output logic             reset_nos,
  output logic [N-1:0]     init_state,
  output logic             start_s0,
  output logic             start_s1,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] meet,
  output logic [CNT_W-1:0] period
);

  gnr_state_e       state_q, state_d;
  logic [N-1:0]     seed_q;
  logic [CNT_W-1:0] max_q;
  logic [CNT_W-1:0] meet_q, meet_d, period_q, period_d;
  logic             done_q, done_d, timeout_q, timeout_d;
  logic             reset_nos_q;

  logic [CNT_W-1:0] p_cnt, lam_cnt;
  logic             p_at_max, lam_at_max;
  logic             cnt_clr, p_en, lam_en;
  logic             s0_pulse, s1_pulse;
  logic             vec_eq, accept;

  assign vec_eq = (s0_vec == s1_vec);
  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  gnr_step_cnt #(.CNT_W(CNT_W)) u_p_cnt (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clr_i      (cnt_clr),
    .en_i       (p_en),
    .limit_i    (max_q),
    .cnt_o      (p_cnt),
    .at_limit_o (p_at_max)
  );

  gnr_step_cnt #(.CNT_W(CNT_W)) u_lam_cnt (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clr_i      (cnt_clr),
    .en_i       (lam_en),
    .limit_i    (max_q),
    .cnt_o      (lam_cnt),
    .at_limit_o (lam_at_max)
  );

  // Step strobes must be suppressed in the very cycle the compare hits, so they
  // decode the registered state and counters rather than a further flop stage.
  always_comb begin
    state_d   = state_q;
    meet_d    = meet_q;
    period_d  = period_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    cnt_clr   = 1'b0;
    p_en      = 1'b0;
    lam_en    = 1'b0;
    s0_pulse  = 1'b0;
    s1_pulse  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cnt_clr   = 1'b1;
          meet_d    = '0;
          period_d  = '0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!p_cnt[0] && (p_cnt >= CNT_W'(2)) && vec_eq) begin
          meet_d  = {1'b0, p_cnt[CNT_W-1:1]};
          state_d = ST_PERIOD;
        end else if (p_at_max) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end else begin
          s0_pulse = 1'b1;
          s1_pulse = 1'b1;
          p_en     = 1'b1;
        end
      end
      ST_PERIOD: begin
        if ((lam_cnt != '0) && vec_eq) begin
          period_d = lam_cnt;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else if (lam_at_max) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end else begin
          s1_pulse = 1'b1;
          lam_en   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      seed_q      <= '0;
      max_q       <= '0;
      meet_q      <= '0;
      period_q    <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      reset_nos_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      meet_q      <= meet_d;
      period_q    <= period_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      reset_nos_q <= accept;
      if (accept) begin
        seed_q <= seed;
        max_q  <= max_steps;
      end
    end
  end

  assign reset_nos  = reset_nos_q;
  assign init_state = seed_q;
  assign start_s0   = s0_pulse;
  assign start_s1   = s1_pulse;
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_PERIOD);
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign meet       = meet_q;
  assign period     = period_q;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// tb/tb_gnr_attractor_ctrl.sv - scoreboard bench for gnr_attractor_ctrl with a behavioural node bank
module tb_gnr_attractor_ctrl;

  localparam int N     = 22;
  localparam int CNT_W = 32;

  typedef struct {
    longint meet;
    longint period;
    longint to;
    longint lat;
    longint s0n;
    longint s1n;
  } exp_t;

  typedef struct {
    string  name;
    longint act;
    longint exp;
  } dchk_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [N-1:0]     seed;
  logic [CNT_W-1:0] max_steps;
  logic [N-1:0]     n_s0, n_s1;
  logic             pass_q;
  logic             reset_nos, start_s0, start_s1, busy, done, timeout;
  logic [N-1:0]     init_state;
  logic [CNT_W-1:0] meet, period;

  bit     osc_mode;
  longint cyc = 0;
  longint t0, b_s0, b_s1;
  longint cnt_s0 = 0, cnt_s1 = 0, n_ovl = 0;
  int     nchk = 0, nfail = 0;
  int     runs_done = 0, exp_runs = 0;
  bit     done_seen = 1'b0;
  exp_t   exp_q[$];
  dchk_t  dq[$];

  gnr_attractor_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed       (seed),
    .max_steps  (max_steps),
    .s0_vec     (n_s0),
    .s1_vec     (n_s1),
    .reset_nos  (reset_nos),
    .init_state (init_state),
    .start_s0   (start_s0),
    .start_s1   (start_s1),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .meet       (meet),
    .period     (period)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] f_next(input logic [N-1:0] x);
    return osc_mode ? ~x : x;
  endfunction

  // Node bank: s1 steps on every hare strobe, s0 on every second tortoise strobe.
  always @(posedge clk) begin
    if (!rst_n) begin
      n_s0   <= '0;
      n_s1   <= '0;
      pass_q <= 1'b0;
    end else if (reset_nos) begin
      n_s0   <= init_state;
      n_s1   <= init_state;
      pass_q <= 1'b1;
    end else begin
      if (start_s1) n_s1 <= f_next(n_s1);
      if (start_s0) begin
        if (pass_q) begin
          pass_q <= 1'b0;
        end else begin
          n_s0   <= f_next(n_s0);
          pass_q <= 1'b1;
        end
      end
    end
  end

  task automatic cmp(input string nm, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    dchk_t d;
    exp_t  e;
    while (dq.size() != 0) begin
      d = dq.pop_front();
      cmp(d.name, d.act, d.exp);
    end
    if (start_s0) cnt_s0++;
    if (start_s1) cnt_s1++;
    if (reset_nos && (start_s0 || start_s1)) n_ovl++;
    if (!rst_n) begin
      done_seen = 1'b0;
    end else if (done && !done_seen) begin
      done_seen = 1'b1;
      if (exp_q.size() == 0) begin
        cmp("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        cmp("meet", meet, e.meet);
        cmp("period", period, e.period);
        cmp("timeout", timeout, e.to);
        cmp("latency", cyc - t0, e.lat);
        cmp("s0_pulses", cnt_s0 - b_s0, e.s0n);
        cmp("s1_pulses", cnt_s1 - b_s1, e.s1n);
        cmp("busy_in_done", busy, 0);
      end
      runs_done++;
    end else if (!done) begin
      done_seen = 1'b0;
    end
  end

  task automatic dchk(input string nm, input longint a, input longint e);
    dchk_t d;
    d.name = nm;
    d.act  = a;
    d.exp  = e;
    dq.push_back(d);
  endtask

  task automatic mk_exp(input longint m, input longint p, input longint to, input longint lat,
                        input longint s0n, input longint s1n, output exp_t e);
    e.meet = m; e.period = p; e.to = to; e.lat = lat; e.s0n = s0n; e.s1n = s1n;
  endtask

  task automatic issue(input logic [N-1:0] sd, input logic [CNT_W-1:0] mx, input bit push, input exp_t e);
    @(negedge clk);
    start     = 1'b1;
    seed      = sd;
    max_steps = mx;
    t0        = cyc;
    b_s0      = cnt_s0;
    b_s1      = cnt_s1;
    if (push) begin
      exp_q.push_back(e);
      exp_runs++;
    end
    @(negedge clk);
    start = 1'b0;
    dchk("reset_nos_load", reset_nos, 1);
    dchk("init_state_load", init_state, sd);
    dchk("busy_load", busy, 1);
    dchk("done_load", done, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (runs_done < exp_runs && n < 400) begin
      @(negedge clk);
      n++;
    end
    dchk("wait_done", runs_done, exp_runs);
  endtask

  task automatic chk_reset_outputs(input string tag);
    dchk({tag, "_reset_nos"}, reset_nos, 0);
    dchk({tag, "_start_s0"}, start_s0, 0);
    dchk({tag, "_start_s1"}, start_s1, 0);
    dchk({tag, "_busy"}, busy, 0);
    dchk({tag, "_done"}, done, 0);
    dchk({tag, "_timeout"}, timeout, 0);
    dchk({tag, "_meet"}, meet, 0);
    dchk({tag, "_period"}, period, 0);
    dchk({tag, "_init_state"}, init_state, 0);
    dchk({tag, "_state"}, longint'(dut.state_q), 0);
  endtask

  initial begin
    exp_t e;
    rst_n     = 1'b0;
    start     = 1'b0;
    seed      = '0;
    max_steps = '0;
    osc_mode  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // fixed point: meet 1, period 1, done at cycle 7
    mk_exp(1, 1, 0, 7, 2, 3, e);
    issue(22'h15A5A5, 32'd100, 1'b1, e);
    wait_done();

    // 2-cycle oscillator from zero
    osc_mode = 1'b1;
    mk_exp(2, 2, 0, 10, 4, 6, e);
    issue(22'h0, 32'd100, 1'b1, e);
    wait_done();

    // budget of 3 runs out in RUN
    mk_exp(0, 0, 1, 6, 3, 3, e);
    issue(22'h0, 32'd3, 1'b1, e);
    wait_done();

    // zero budget: immediate timeout
    osc_mode = 1'b0;
    mk_exp(0, 0, 1, 3, 0, 0, e);
    issue(22'h2AAAAA, 32'd0, 1'b1, e);
    wait_done();

    // start during RUN is ignored
    mk_exp(1, 1, 0, 7, 2, 3, e);
    issue(22'h0F0F0F, 32'd100, 1'b1, e);
    @(negedge clk);
    start     = 1'b1;
    seed      = 22'h3FFFFF;
    max_steps = 32'd0;
    @(negedge clk);
    start = 1'b0;
    dchk("busy_ignore_init", init_state, 22'h0F0F0F);
    dchk("busy_ignore_busy", busy, 1);
    wait_done();
    dchk("busy_ignore_init_after", init_state, 22'h0F0F0F);

    // reset during PERIOD
    osc_mode = 1'b1;
    issue(22'h0, 32'd100, 1'b0, e);
    repeat (6) @(negedge clk);
    dchk("in_period_state", longint'(dut.state_q), 3);
    dchk("in_period_s1", start_s1, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst_n    = 1'b1;
    osc_mode = 1'b0;
    mk_exp(1, 1, 0, 7, 2, 3, e);
    issue(22'h123456 & 22'h3FFFFF, 32'd100, 1'b1, e);
    wait_done();

    // back-to-back: oscillator then fixed point started straight from DONE
    osc_mode = 1'b1;
    mk_exp(2, 2, 0, 10, 4, 6, e);
    issue(22'h00FF00, 32'd50, 1'b1, e);
    wait_done();
    dchk("b2b_done_before", done, 1);
    osc_mode = 1'b0;
    mk_exp(1, 1, 0, 7, 2, 3, e);
    issue(22'h3C3C3C, 32'd50, 1'b1, e);
    wait_done();
    dchk("b2b_init_state", init_state, 22'h3C3C3C);

    dchk("strobe_overlap", n_ovl, 0);
    dchk("scoreboard_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
